// File: rtl/locked_reg_pkg.sv
// Shared definitions for the locked register access arbiter.
// FSM state encodings and default security parameters.
package locked_reg_pkg;

  localparam int          ID_W_DEF       = 2;
  localparam logic [1:0]  ALLOWED_ID_DEF = 2'h2;
  localparam int          VIOL_W_DEF     = 8;

  // Controller states: grant in IDLE, judge in CHECK, report in RESP.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CHECK = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around. The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       any_req_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   j;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IDX_W'(j);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/locked_reg_access_arbiter.sv
// Locked register access arbiter: round-robin grants one requester at a
// time, latches its ID/data at grant, and only lets ALLOWED_ID update the
// protected register. Rejections are flagged and counted (saturating).
// Optional audit outputs are enabled by defining LOCKED_REG_AUDIT_EN.
module locked_reg_access_arbiter
  import locked_reg_pkg::*;
#(
  parameter int              NUM_REQ    = 4,
  parameter int              DATA_W     = 8,
  parameter int              ID_W       = ID_W_DEF,
  parameter logic [ID_W-1:0] ALLOWED_ID = ID_W'(ALLOWED_ID_DEF),
  parameter int              VIOL_W     = VIOL_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ID_W-1:0]     req_usr_id,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           data_out,
  output logic                        resp_valid,
  output logic                        resp_denied,
  output logic [$clog2(NUM_REQ)-1:0]  resp_idx,
  output logic [VIOL_W-1:0]           viol_count
`ifdef LOCKED_REG_AUDIT_EN
  ,
  output logic                        audit_valid,
  output logic [ID_W-1:0]             audit_id,
  output logic [DATA_W-1:0]           audit_data
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DATA_W-1:0]  ldata_q, ldata_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               denied_q, denied_d;
  logic [VIOL_W-1:0]  viol_q, viol_d;
`ifdef LOCKED_REG_AUDIT_EN
  logic [ID_W-1:0]    aud_id_q, aud_id_d;
  logic [DATA_W-1:0]  aud_data_q, aud_data_d;
`endif

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  // Next-state: grant+latch in IDLE, judge the latched ID in CHECK.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    id_d     = id_q;
    ldata_d  = ldata_q;
    data_d   = data_q;
    denied_d = denied_q;
    viol_d   = viol_q;
`ifdef LOCKED_REG_AUDIT_EN
    aud_id_d   = aud_id_q;
    aud_data_d = aud_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          idx_d   = gnt_idx;
          id_d    = req_usr_id[gnt_idx*ID_W +: ID_W];
          ldata_d = req_data[gnt_idx*DATA_W +: DATA_W];
          ptr_d   = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Only the ID captured at grant matters; live inputs are ignored.
        if (id_q == ALLOWED_ID) begin
          data_d   = ldata_q;
          denied_d = 1'b0;
        end else begin
          denied_d = 1'b1;
          if (viol_q != '1) viol_d = viol_q + VIOL_W'(1);
`ifdef LOCKED_REG_AUDIT_EN
          aud_id_d   = id_q;
          aud_data_d = ldata_q;
`endif
        end
        state_d = ST_CHECK + 2'd1;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      id_q     <= '0;
      ldata_q  <= '0;
      data_q   <= '0;
      denied_q <= 1'b0;
      viol_q   <= '0;
`ifdef LOCKED_REG_AUDIT_EN
      aud_id_q   <= '0;
      aud_data_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      id_q     <= id_d;
      ldata_q  <= ldata_d;
      data_q   <= data_d;
      denied_q <= denied_d;
      viol_q   <= viol_d;
`ifdef LOCKED_REG_AUDIT_EN
      aud_id_q   <= aud_id_d;
      aud_data_q <= aud_data_d;
`endif
    end
  end

  // Accept only from IDLE; held low while reset is asserted.
  assign req_ready   = (rst_n && state_q == ST_IDLE) ? gnt : '0;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_denied = resp_valid & denied_q;
  assign resp_idx    = resp_valid ? idx_q : '0;
  assign data_out    = data_q;
  assign viol_count  = viol_q;
`ifdef LOCKED_REG_AUDIT_EN
  assign audit_valid = resp_valid & denied_q;
  assign audit_id    = aud_id_q;
  assign audit_data  = aud_data_q;
`endif

endmodule

// File: tb/tb_locked_reg_access_arbiter.sv
// Self-checking bench for locked_reg_access_arbiter: directed scenarios plus
// random traffic, compared every cycle against a transaction-level model.
module tb_locked_reg_access_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_usr_id;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  data_out;
  logic        resp_valid, resp_denied;
  logic [1:0]  resp_idx;
  logic [7:0]  viol_count;
`ifdef LOCKED_REG_AUDIT_EN
  logic        audit_valid;
  logic [1:0]  audit_id;
  logic [7:0]  audit_data;
`endif

  locked_reg_access_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_usr_id(req_usr_id),
    .req_data(req_data), .req_ready(req_ready), .data_out(data_out),
    .resp_valid(resp_valid), .resp_denied(resp_denied), .resp_idx(resp_idx),
    .viol_count(viol_count)
`ifdef LOCKED_REG_AUDIT_EN
    , .audit_valid(audit_valid), .audit_id(audit_id), .audit_data(audit_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: phase counts cycles since the last grant.
  int         m_phase, m_ptr, m_gidx;
  logic [1:0] m_lid;
  logic [7:0] m_ldata, m_data, m_viol, m_aud_id, m_aud_data;
  logic       m_ok;
  int         glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, then advance model at the edge.
  task automatic step();
    int g;
    logic [3:0] er;
    #1;
    g  = (m_phase == 0) ? pick(req_valid, m_ptr) : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    if (rst_n) begin
      chk("req_ready", req_ready, er);
      chk("resp_valid", resp_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("resp_denied", resp_denied, !m_ok);
        chk("resp_idx", resp_idx, m_gidx);
      end
      chk("data_out", data_out, m_data);
      chk("viol_count", viol_count, m_viol);
`ifdef LOCKED_REG_AUDIT_EN
      chk("audit_valid", audit_valid, (m_phase == 2) && !m_ok);
      chk("audit_id", audit_id, m_aud_id);
      chk("audit_data", audit_data, m_aud_data);
`endif
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_data = '0; m_viol = '0;
      m_aud_id = '0; m_aud_data = '0;
    end else if (m_phase == 0) begin
      if (g >= 0) begin
        m_gidx  = g;
        m_lid   = req_usr_id[g*2 +: 2];
        m_ldata = req_data[g*8 +: 8];
        m_ptr   = (g + 1) % NREQ;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_ok = (m_lid == 2'h2);
      if (m_ok) m_data = m_ldata;
      else begin
        if (m_viol != 8'hFF) m_viol = m_viol + 8'd1;
        m_aud_id   = {6'd0, m_lid};
        m_aud_data = m_ldata;
      end
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [1:0] id, input logic [7:0] d);
    req_usr_id[i*2 +: 2] = id;
    req_data[i*8 +: 8]   = d;
    req_valid[i]         = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_usr_id = '0; req_data = '0;
    m_phase = 0; m_ptr = 0; m_gidx = 0; m_lid = '0; m_ldata = '0;
    m_data = '0; m_viol = '0; m_aud_id = '0; m_aud_data = '0; m_ok = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    step();
    chk("rst_data", data_out, 8'h00);
    chk("rst_viol", viol_count, 8'h00);

    // Single allowed write
    set_req(0, 2'h2, 8'hA5);
    #1 chk("t1_ready", req_ready, 4'b0001);
    step(); req_valid = '0;
    step();
    chk("t1_resp", resp_valid, 1'b1);
    chk("t1_denied", resp_denied, 1'b0);
    chk("t1_idx", resp_idx, 2'd0);
    chk("t1_data", data_out, 8'hA5);
    chk("t1_viol", viol_count, 8'h00);
    step();

    // Denied write
    set_req(1, 2'h1, 8'h3C);
    step(); req_valid = '0;
    step();
    chk("t2_resp", resp_valid, 1'b1);
    chk("t2_denied", resp_denied, 1'b1);
    chk("t2_idx", resp_idx, 2'd1);
    chk("t2_data", data_out, 8'hA5);
    chk("t2_viol", viol_count, 8'h01);
`ifdef LOCKED_REG_AUDIT_EN
    chk("t2_aud_id", audit_id, 2'h1);
    chk("t2_aud_data", audit_data, 8'h3C);
`endif
    step();

    // Fairness from a fresh pointer
    do_reset();
    glog.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'h2, 8'h10 + 8'(i));
    for (int c = 0; c < 13; c++) step();
    req_valid = '0;
    step(); step();
    chk("fair_cnt", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("fair_g0", glog[0], 0);
      chk("fair_g1", glog[1], 1);
      chk("fair_g2", glog[2], 2);
      chk("fair_g3", glog[3], 3);
      chk("fair_g4", glog[4], 0);
    end
    chk("fair_data", data_out, 8'h10);

    // ID swap after accept: allowed stays allowed
    set_req(2, 2'h2, 8'h5A);
    step(); req_valid = '0;
    req_usr_id[4 +: 2] = 2'h0; req_data[16 +: 8] = 8'hFF;
    step();
    chk("swap1_denied", resp_denied, 1'b0);
    chk("swap1_data", data_out, 8'h5A);
    step();
    // Reverse: denied stays denied
    set_req(2, 2'h0, 8'h77);
    step(); req_valid = '0;
    req_usr_id[4 +: 2] = 2'h2;
    step();
    chk("swap2_denied", resp_denied, 1'b1);
    chk("swap2_data", data_out, 8'h5A);
    step();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      req_usr_id = 8'($urandom);
      req_data   = $urandom;
      step();
    end
    req_valid = '0;
    step(); step(); step();

    // Saturation: 300 denied writes
    do_reset();
    set_req(3, 2'h0, 8'hEE);
    for (int c = 0; c < 900; c++) step();
    req_valid = '0;
    step();
    chk("sat_viol", viol_count, 8'hFF);
    chk("sat_data", data_out, 8'h00);

    // Reset asserted during CHECK drops the transaction
    set_req(1, 2'h2, 8'h99);
    step(); req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rchk_resp", resp_valid, 1'b0);
    chk("rchk_data", data_out, 8'h00);
    chk("rchk_viol", viol_count, 8'h00);
    step();
    chk("rchk_resp2", resp_valid, 1'b0);
    for (int i = 0; i < NREQ; i++) set_req(i, 2'h2, 8'h40 + 8'(i));
    #1 chk("rchk_ptr", req_ready, 4'b0001);
    step(); req_valid = '0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
